// File: rtl/fft_pkg.sv
// fft_pkg: shared types and defaults for the FFT frame feeder.
//   FRAME_LEN_DEF    : default samples per FFT frame (power of two, >= 4)
//   SAMPLE_WIDTH_DEF : default signed audio sample width (<= 16)
//   bank_state_t     : lifecycle of one ping-pong bank
//   stream_state_t   : AXI-Stream output sequencer states
package fft_pkg;

  localparam int FRAME_LEN_DEF    = 1024;
  localparam int SAMPLE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FILLING   = 2'd1,
    FULL      = 2'd2,
    STREAMING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } stream_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram: simple dual-port sample store holding both ping-pong banks.
//   clk_i   : clock
//   we_i    : write strobe
//   waddr_i : write address {bank, ptr}
//   wdata_i : write data
//   raddr_i : read address {bank, ptr}
//   rdata_o : read data, registered (valid one cycle after raddr_i)
// No reset on the array or read register so it maps onto block RAM.
module frame_bank_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: packs audio samples into FRAME_LEN frames using two
// ping-pong banks and streams each full frame to the FFT over AXI-Stream.
//   clk_in / rst_in    : clock, async active-high reset
//   enable_in          : capture enable; low discards the partial frame
//   audio_valid_in     : one-cycle sample strobe
//   audio_in           : signed sample
//   m_axis_tdata       : [15:0] = {sample, zero pad}, [31:16] = 0
//   m_axis_tvalid/tlast/tready : AXI-Stream master
//   frame_count_out    : frames completed (wraps)
//   overflow_out       : sticky, a sample was dropped
//   busy_out           : some bank is FULL or STREAMING
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int FRAME_LEN    = FRAME_LEN_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic                    audio_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  output logic [31:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [15:0]             frame_count_out,
  output logic                    overflow_out,
  output logic                    busy_out
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  bank_state_t   bank_q [2];
  bank_state_t   bank_d [2];
  stream_state_t st_q, st_d;
  logic          fill_q, fill_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          rd_bank_q, rd_bank_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic                    we;
  logic                    hs;
  logic                    other_bank;
  logic [SAMPLE_WIDTH-1:0] rdata;
  logic [15:0]             re_part;

  assign hs         = (st_q == SEND) && m_axis_tready;
  assign other_bank = ~rd_bank_q;

  // Bank updates are applied in a fixed order so same-cycle events compose:
  // retire the draining bank, then capture (which may reuse the bank that
  // just emptied), then start streaming the next full bank.
  always_comb begin
    bank_d    = bank_q;
    st_d      = st_q;
    fill_d    = fill_q;
    wr_ptr_d  = wr_ptr_q;
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    we        = 1'b0;

    if (hs) begin
      if (rd_ptr_q == LAST) begin
        bank_d[rd_bank_q] = EMPTY;
        cnt_d             = cnt_q + 16'd1;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (!enable_in) begin
      wr_ptr_d = '0;
      if (bank_d[fill_q] == FILLING) bank_d[fill_q] = EMPTY;
    end else if (audio_valid_in) begin
      if (bank_d[fill_q] == EMPTY || bank_d[fill_q] == FILLING) begin
        we = 1'b1;
        if (wr_ptr_q == LAST) begin
          bank_d[fill_q] = FULL;
          wr_ptr_d       = '0;
          fill_d         = ~fill_q;
        end else begin
          bank_d[fill_q] = FILLING;
          wr_ptr_d       = wr_ptr_q + 1'b1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Banks fill alternately and are drained alternately, so rd_bank_q is
    // always the oldest frame. A bank completing this cycle is seen at once
    // to keep the start latency down.
    case (st_q)
      IDLE: begin
        if (bank_d[rd_bank_q] == FULL) begin
          bank_d[rd_bank_q] = STREAMING;
          rd_ptr_d          = '0;
          st_d              = LOAD;
        end
      end
      LOAD: st_d = SEND;
      SEND: begin
        if (hs && rd_ptr_q == LAST) begin
          rd_bank_d = other_bank;
          rd_ptr_d  = '0;
          // The read of word 0 of the next bank is issued on the tlast beat
          // itself, standing in for a LOAD cycle: with samples arriving every
          // cycle a bubble per frame would eventually overflow the banks.
          if (bank_d[other_bank] == FULL) bank_d[other_bank] = STREAMING;
          else                            st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      st_q      <= IDLE;
      fill_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      st_q      <= st_d;
      fill_q    <= fill_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_bank_q <= rd_bank_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Reading the next-state pointer makes the RAM output register act as the
  // output data register: it re-reads the same word while stalled and the
  // following word on a handshake, giving back-to-back beats.
  frame_bank_ram #(
    .DEPTH (2 * FRAME_LEN),
    .WIDTH (SAMPLE_WIDTH)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (we),
    .waddr_i ({fill_q, wr_ptr_q}),
    .wdata_i (audio_in),
    .raddr_i ({rd_bank_d, rd_ptr_d}),
    .rdata_o (rdata)
  );

  // Sample sits in the top bits of the 16-bit real part.
  assign re_part = 16'(rdata) << (16 - SAMPLE_WIDTH);

  assign m_axis_tvalid   = (st_q == SEND);
  assign m_axis_tlast    = m_axis_tvalid && (rd_ptr_q == LAST);
  assign m_axis_tdata    = m_axis_tvalid ? {16'h0000, re_part} : 32'h0;
  assign frame_count_out = cnt_q;
  assign overflow_out    = ovf_q;
  assign busy_out        = (bank_q[0] == FULL) || (bank_q[0] == STREAMING) ||
                           (bank_q[1] == FULL) || (bank_q[1] == STREAMING);

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
- Sits between the 12 kHz mic decimator / recorder audio output and the xfft_1 input port.
- Collects signed 8-bit audio samples into fixed-length frames using two ping-pong banks.
- Streams each complete frame to the FFT as AXI-Stream with tlast on the final sample. The next frame fills while the current one drains.
- Replaces the ad-hoc fft_valid/fft_last logic in top level.

Parameters:
- FRAME_LEN, 1024, samples per FFT frame; power of two, ≥4; must match the FFT core transform length.
- SAMPLE_WIDTH, 8, width of the signed audio sample.

Ports:
- clk_in  input  1  system clock (98.3 MHz)
- rst_in  input  1  asynchronous active-high reset
- enable_in  input  1  frame capture enable
- audio_valid_in  input  1  single-cycle sample strobe
- audio_in  input  SAMPLE_WIDTH  signed audio sample
- m_axis_tdata  output  32  [15:0] real = {audio_in, (16-SAMPLE_WIDTH) zeros}; [31:16] imag = 0
- m_axis_tvalid  output  1  AXI valid
- m_axis_tlast  output  1  asserted on sample FRAME_LEN-1 of the frame
- m_axis_tready  input  1  AXI ready from the FFT core
- frame_count_out  output  16  completed frames sent; wraps 65535→0
- overflow_out  output  1  sticky flag: a sample was dropped
- busy_out  output  1  high while any bank is full or streaming

Behaviour:
- Reset (async assert, sync release): all outputs 0, both banks EMPTY, write pointer 0, fill bank = 0.
- Bank states: EMPTY → FILLING → FULL → STREAMING → EMPTY.
- Capture:
  - On audio_valid_in && enable_in, write audio_in to the fill bank at wr_ptr, then increment wr_ptr.
  - When wr_ptr reaches FRAME_LEN-1 and that write occurs, the bank becomes FULL, wr_ptr = 0, and the fill bank toggles.
- Overflow:
  - If the target bank is not EMPTY/FILLING (both banks occupied), drop the sample and set overflow_out.
  - overflow_out clears only on reset.
- enable_in low:
  - Clears wr_ptr; the partial frame in the fill bank is discarded (returns to EMPTY).
  - FULL/STREAMING banks still drain.
- Stream FSM, states IDLE, LOAD, SEND:
  - IDLE → LOAD when the oldest bank is FULL; banks are served in fill order.
  - LOAD issues the RAM read of address 0 (1-cycle read latency).
  - SEND holds m_axis_tvalid=1.
  - On each tvalid&&tready: advance rd_ptr. The next word must be presented on the following cycle with no bubble, using a prefetch register or skid.
  - m_axis_tlast=1 exactly when rd_ptr==FRAME_LEN-1.
  - On the tlast handshake: bank → EMPTY, frame_count_out += 1, and the FSM goes → LOAD if the other bank is FULL, otherwise → IDLE (tvalid=0).
- AXI rules:
  - While tvalid && !tready, tdata/tlast are held stable.
  - tvalid never drops mid-frame except on reset.
  - tvalid does not depend combinationally on tready.
- Throughput: one sample per cycle when tready=1. Frame latency from the FULL transition to the first tvalid is ≤3 cycles.
- Simultaneous events:
  - A capture write into one bank and a stream read from the other in the same cycle is legal (dual-port).
  - A bank emptying on the same cycle a sample targets it: the sample is accepted.
- Reset mid-stream: tvalid drops immediately, and the partial frame is lost. The downstream FFT is expected to flag tlast_missing; this is acceptable.
- busy_out = any bank FULL or STREAMING.

Decomposition:
- fft_pkg: FRAME_LEN default, SAMPLE_WIDTH, bank_state_t enum (EMPTY/FILLING/FULL/STREAMING), stream_state_t enum (IDLE/LOAD/SEND).
- Sub-module frame_bank_ram:
  - simple dual-port RAM, 2*FRAME_LEN x SAMPLE_WIDTH, address = {bank, ptr};
  - registered read, 1-cycle latency;
  - inferable as BRAM.

Test Plan (FRAME_LEN=8 for sim):
- Basic frame: enable=1, tready=1, 8 samples -4..3 at 12-cycle spacing → 8 beats with tdata[15:0]=0xFC00,0xFD00,…,0x0300, tdata[31:16]=0, tlast only on 0x0300, frame_count_out=1.
- Backpressure: tready toggling 1,0,0,1… during the frame → every beat held stable while stalled, all 8 delivered in order, no duplicates.
- Overflow: tready=0, 20 samples → banks hold samples 0–7 and 8–15, overflow_out=1, samples 16–19 dropped. Then tready=1 → 16 beats, two tlasts, frame_count_out=2.
- Enable drop: 5 samples, enable low, enable high, 8 samples → exactly one frame containing only the last 8 samples.
- Back-to-back: continuous samples every cycle with tready=1 → frames stream with tvalid gap ≤3 cycles, overflow_out stays 0.
- Reset mid-stream: assert rst_in at beat 3 → tvalid/tlast/frame_count_out/overflow_out = 0 immediately. A fresh 8-sample frame afterwards streams correctly.
